// File: rtl/integral_read_arbiter_pkg.sv
// Shared definitions for the integral image cache read arbiter:
// requester ids, arbiter FSM states and the response tag entry.
package integral_read_arbiter_pkg;

    // Requester ids as seen on req_*/rsp_valid bit positions
    localparam logic REQ_VAR = 1'b0;
    localparam logic REQ_WIN = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } arb_state_t;

    // One in-flight read: whether it exists and who issued it
    typedef struct packed {
        logic valid;
        logic id;
    } rsp_tag_t;

endpackage

// File: rtl/integral_read_arbiter_if.sv
// Request/response bundle between the two loaders, the arbiter and the
// integral image cache read port. The arbiter uses the slave view.
interface integral_read_arbiter_if #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 32
) ();

    logic [1:0]        req_valid;
    logic [ADDR_W-1:0] req_addr0;
    logic [ADDR_W-1:0] req_addr1;
    logic [1:0]        req_last;
    logic [1:0]        req_ready;
    logic [1:0]        rsp_valid;
    logic [DATA_W-1:0] rsp_data;
    logic              cache_rd_en;
    logic [ADDR_W-1:0] cache_addr;
    logic [DATA_W-1:0] cache_rd_data;
    logic              idle;
    logic              grant_owner;

    modport slave (
        input  req_valid, req_addr0, req_addr1, req_last, cache_rd_data,
        output req_ready, rsp_valid, rsp_data, cache_rd_en, cache_addr,
               idle, grant_owner
    );

    modport master (
        output req_valid, req_addr0, req_addr1, req_last, cache_rd_data,
        input  req_ready, rsp_valid, rsp_data, cache_rd_en, cache_addr,
               idle, grant_owner
    );

endinterface

// File: rtl/integral_read_arbiter_rsp_tag_pipe.sv
// Fixed-depth shift register of response tags that tracks which requester
// each cache read belongs to, matching the cache read latency.
module rsp_tag_pipe
    import integral_read_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic     clk,
    input  logic     resetn,
    input  rsp_tag_t tag_in,
    output rsp_tag_t tag_out,
    output logic     any_valid
);

    rsp_tag_t [DEPTH-1:0] stage;

    // Advance every cycle; reset drops all in-flight tags
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stage <= '0;
        end else begin
            stage[0] <= tag_in;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign tag_out = stage[DEPTH-1];

    // Any tag still travelling means a response is still owed
    always_comb begin
        any_valid = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            any_valid = any_valid | stage[i].valid;
        end
    end

endmodule

// File: rtl/integral_read_arbiter.sv
// Round-robin, burst-locked arbiter sharing the integral image cache read
// port between the variance loader (0) and the window loader (1), with
// per-beat tagging so each response returns to its issuer.
module integral_read_arbiter
    import integral_read_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W     = 16,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned RD_LATENCY = 2
) (
    input logic                   clk,
    input logic                   resetn,
    integral_read_arbiter_if.slave bus
);

    arb_state_t        state;
    arb_state_t        state_next;
    logic              last_served;
    logic [ADDR_W-1:0] addr_q;
    logic              owner;
    logic [1:0]        ready;
    logic              accept;
    logic [ADDR_W-1:0] beat_addr;
    logic              beat_last;
    rsp_tag_t          tag_in;
    rsp_tag_t          tag_out;
    logic              pipe_busy;
    logic [DATA_W-1:0] rd_data;

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state: arbitrate in IDLE, release ownership on an accepted last beat
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                case (bus.req_valid)
                    2'b01:   state_next = ST_OWN0;
                    2'b10:   state_next = ST_OWN1;
                    2'b11:   state_next = (last_served == REQ_WIN) ? ST_OWN0 : ST_OWN1;
                    default: state_next = ST_IDLE;
                endcase
            end
            ST_OWN0, ST_OWN1: begin
                if (accept && beat_last) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Outputs: open only the owner's lane and pass its beat straight to the cache
    always_comb begin
        owner     = last_served;
        ready     = 2'b00;
        accept    = 1'b0;
        beat_addr = bus.req_addr0;
        beat_last = 1'b0;
        case (state)
            ST_OWN0: begin
                owner     = REQ_VAR;
                ready     = 2'b01;
                accept    = bus.req_valid[0];
                beat_addr = bus.req_addr0;
                beat_last = bus.req_last[0];
            end
            ST_OWN1: begin
                owner     = REQ_WIN;
                ready     = 2'b10;
                accept    = bus.req_valid[1];
                beat_addr = bus.req_addr1;
                beat_last = bus.req_last[1];
            end
            default: ;
        endcase
    end

    // Round-robin history and the address last presented to the cache
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            last_served <= REQ_WIN;
            addr_q      <= '0;
        end else if (accept) begin
            addr_q <= beat_addr;
            if (beat_last) begin
                last_served <= owner;
            end
        end
    end

    assign tag_in = {accept, owner};

    rsp_tag_pipe #(
        .DEPTH (RD_LATENCY)
    ) u_rsp_tag_pipe (
        .clk       (clk),
        .resetn    (resetn),
        .tag_in    (tag_in),
        .tag_out   (tag_out),
        .any_valid (pipe_busy)
    );

    assign rd_data         = bus.cache_rd_data;
    assign bus.rsp_data    = rd_data;
    assign bus.rsp_valid   = {tag_out.valid & (tag_out.id == REQ_WIN),
                              tag_out.valid & (tag_out.id == REQ_VAR)};
    assign bus.req_ready   = ready;
    assign bus.cache_rd_en = accept;
    assign bus.cache_addr  = accept ? beat_addr : addr_q;
    assign bus.grant_owner = owner;
    assign bus.idle        = (state == ST_IDLE) && !pipe_busy;

endmodule

// File: tb/tb_integral_read_arbiter.sv
// Directed bench: two arbiter instances (read latency 2 and 3) share one
// stimulus stream; each has a simple latency-matched cache model.
module tb_integral_read_arbiter;

    localparam int unsigned AW = 16;
    localparam int unsigned DW = 32;

    logic clk    = 1'b0;
    logic resetn = 1'b0;
    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    always #5 clk = ~clk;

    integral_read_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus2 ();
    integral_read_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus3 ();

    integral_read_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(2)) dut2 (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus2)
    );

    integral_read_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(3)) dut3 (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus3)
    );

    assign bus3.req_valid = bus2.req_valid;
    assign bus3.req_addr0 = bus2.req_addr0;
    assign bus3.req_addr1 = bus2.req_addr1;
    assign bus3.req_last  = bus2.req_last;

    function automatic logic [31:0] cdata(input logic [15:0] a);
        return {16'hC0DE, a};
    endfunction

    // Cache models: data for an address appears RD_LATENCY cycles after the strobe
    logic [1:0]  c2_en = '0;
    logic [15:0] c2_a [2];
    logic [2:0]  c3_en = '0;
    logic [15:0] c3_a [3];

    always @(posedge clk) begin
        c2_en   <= {c2_en[0], bus2.cache_rd_en};
        c2_a[0] <= bus2.cache_addr;
        c2_a[1] <= c2_a[0];
        c3_en   <= {c3_en[1:0], bus3.cache_rd_en};
        c3_a[0] <= bus3.cache_addr;
        c3_a[1] <= c3_a[0];
        c3_a[2] <= c3_a[1];
    end

    assign bus2.cache_rd_data = c2_en[1] ? cdata(c2_a[1]) : 32'h0;
    assign bus3.cache_rd_data = c3_en[2] ? cdata(c3_a[2]) : 32'h0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input string tag, input logic [1:0] rv, input logic [1:0] last,
                       input logic [15:0] a0, input logic [15:0] a1,
                       input logic [1:0] e_rdy, input logic e_en, input logic [15:0] e_addr,
                       input logic [1:0] e_rsp, input logic [15:0] e_daddr,
                       input logic e_idle, input logic e_own);
        @(posedge clk);
        #1;
        bus2.req_valid = rv;
        bus2.req_last  = last;
        bus2.req_addr0 = a0;
        bus2.req_addr1 = a1;
        #3;
        chk($sformatf("%s req_ready", tag), bus2.req_ready, e_rdy);
        chk($sformatf("%s cache_rd_en", tag), bus2.cache_rd_en, e_en);
        chk($sformatf("%s cache_addr", tag), bus2.cache_addr, e_addr);
        chk($sformatf("%s rsp_valid", tag), bus2.rsp_valid, e_rsp);
        if (e_rsp != 2'b00) chk($sformatf("%s rsp_data", tag), bus2.rsp_data, cdata(e_daddr));
        chk($sformatf("%s idle", tag), bus2.idle, e_idle);
        chk($sformatf("%s grant_owner", tag), bus2.grant_owner, e_own);
    endtask

    task automatic chk3(input string tag, input logic [1:0] e_rsp, input logic [15:0] e_daddr,
                        input logic e_idle);
        chk($sformatf("%s lat3 rsp_valid", tag), bus3.rsp_valid, e_rsp);
        if (e_rsp != 2'b00) chk($sformatf("%s lat3 rsp_data", tag), bus3.rsp_data, cdata(e_daddr));
        chk($sformatf("%s lat3 idle", tag), bus3.idle, e_idle);
    endtask

    task automatic chk_reset(input string tag);
        chk($sformatf("%s rst req_ready", tag), bus2.req_ready, 2'b00);
        chk($sformatf("%s rst rsp_valid", tag), bus2.rsp_valid, 2'b00);
        chk($sformatf("%s rst cache_rd_en", tag), bus2.cache_rd_en, 1'b0);
        chk($sformatf("%s rst cache_addr", tag), bus2.cache_addr, 16'h0);
        chk($sformatf("%s rst idle", tag), bus2.idle, 1'b1);
        chk($sformatf("%s rst grant_owner", tag), bus2.grant_owner, 1'b1);
        chk($sformatf("%s rst lat3 rsp_valid", tag), bus3.rsp_valid, 2'b00);
        chk($sformatf("%s rst lat3 idle", tag), bus3.idle, 1'b1);
    endtask

    task automatic do_reset(input string tag);
        @(posedge clk);
        #1;
        resetn         = 1'b0;
        bus2.req_valid = 2'b00;
        bus2.req_last  = 2'b00;
        bus2.req_addr0 = 16'h0;
        bus2.req_addr1 = 16'h0;
        #1;
        chk_reset(tag);
        @(posedge clk);
        #1;
        resetn = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed no finish expected finish within 100us");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus2.req_valid = 2'b00;
        bus2.req_last  = 2'b00;
        bus2.req_addr0 = 16'h0;
        bus2.req_addr1 = 16'h0;

        // Single requester, 4-beat burst 0x10..0x13
        do_reset("t1");
        cyc("t1c1", 2'b01, 2'b00, 16'h10, 16'h0, 2'b00, 1'b0, 16'h00, 2'b00, 16'h0,  1'b1, 1'b1);
        cyc("t1c2", 2'b01, 2'b00, 16'h10, 16'h0, 2'b01, 1'b1, 16'h10, 2'b00, 16'h0,  1'b0, 1'b0);
        cyc("t1c3", 2'b01, 2'b00, 16'h11, 16'h0, 2'b01, 1'b1, 16'h11, 2'b00, 16'h0,  1'b0, 1'b0);
        cyc("t1c4", 2'b01, 2'b00, 16'h12, 16'h0, 2'b01, 1'b1, 16'h12, 2'b01, 16'h10, 1'b0, 1'b0);
        cyc("t1c5", 2'b01, 2'b01, 16'h13, 16'h0, 2'b01, 1'b1, 16'h13, 2'b01, 16'h11, 1'b0, 1'b0);
        cyc("t1c6", 2'b00, 2'b00, 16'h13, 16'h0, 2'b00, 1'b0, 16'h13, 2'b01, 16'h12, 1'b0, 1'b0);
        cyc("t1c7", 2'b00, 2'b00, 16'h13, 16'h0, 2'b00, 1'b0, 16'h13, 2'b01, 16'h13, 1'b0, 1'b0);
        cyc("t1c8", 2'b00, 2'b00, 16'h13, 16'h0, 2'b00, 1'b0, 16'h13, 2'b00, 16'h0,  1'b1, 1'b0);

        // Contention from reset: 0 first, bubble, then 1, then 0 again
        do_reset("t2");
        cyc("t2c1",  2'b11, 2'b00, 16'h20, 16'h30, 2'b00, 1'b0, 16'h00, 2'b00, 16'h0,  1'b1, 1'b1);
        cyc("t2c2",  2'b11, 2'b00, 16'h20, 16'h30, 2'b01, 1'b1, 16'h20, 2'b00, 16'h0,  1'b0, 1'b0);
        cyc("t2c3",  2'b11, 2'b01, 16'h21, 16'h30, 2'b01, 1'b1, 16'h21, 2'b00, 16'h0,  1'b0, 1'b0);
        cyc("t2c4",  2'b10, 2'b00, 16'h21, 16'h30, 2'b00, 1'b0, 16'h21, 2'b01, 16'h20, 1'b0, 1'b0);
        cyc("t2c5",  2'b10, 2'b00, 16'h21, 16'h30, 2'b10, 1'b1, 16'h30, 2'b01, 16'h21, 1'b0, 1'b1);
        cyc("t2c6",  2'b11, 2'b10, 16'h22, 16'h31, 2'b10, 1'b1, 16'h31, 2'b00, 16'h0,  1'b0, 1'b1);
        cyc("t2c7",  2'b11, 2'b00, 16'h22, 16'h31, 2'b00, 1'b0, 16'h31, 2'b10, 16'h30, 1'b0, 1'b1);
        cyc("t2c8",  2'b11, 2'b01, 16'h22, 16'h31, 2'b01, 1'b1, 16'h22, 2'b10, 16'h31, 1'b0, 1'b0);
        cyc("t2c9",  2'b00, 2'b00, 16'h22, 16'h31, 2'b00, 1'b0, 16'h22, 2'b00, 16'h0,  1'b0, 1'b0);
        cyc("t2c10", 2'b00, 2'b00, 16'h22, 16'h31, 2'b00, 1'b0, 16'h22, 2'b01, 16'h22, 1'b0, 1'b0);
        cyc("t2c11", 2'b00, 2'b00, 16'h22, 16'h31, 2'b00, 1'b0, 16'h22, 2'b00, 16'h0,  1'b1, 1'b0);

        // Owner pauses 3 cycles mid-burst (with a stray req_last) while 1 waits
        do_reset("t3");
        cyc("t3c1",  2'b01, 2'b00, 16'h40, 16'h50, 2'b00, 1'b0, 16'h00, 2'b00, 16'h0,  1'b1, 1'b1);
        cyc("t3c2",  2'b01, 2'b00, 16'h40, 16'h50, 2'b01, 1'b1, 16'h40, 2'b00, 16'h0,  1'b0, 1'b0);
        cyc("t3c3",  2'b10, 2'b01, 16'h40, 16'h50, 2'b01, 1'b0, 16'h40, 2'b00, 16'h0,  1'b0, 1'b0);
        cyc("t3c4",  2'b10, 2'b00, 16'h40, 16'h50, 2'b01, 1'b0, 16'h40, 2'b01, 16'h40, 1'b0, 1'b0);
        cyc("t3c5",  2'b10, 2'b00, 16'h40, 16'h50, 2'b01, 1'b0, 16'h40, 2'b00, 16'h0,  1'b0, 1'b0);
        cyc("t3c6",  2'b11, 2'b01, 16'h41, 16'h50, 2'b01, 1'b1, 16'h41, 2'b00, 16'h0,  1'b0, 1'b0);
        cyc("t3c7",  2'b10, 2'b00, 16'h41, 16'h50, 2'b00, 1'b0, 16'h41, 2'b00, 16'h0,  1'b0, 1'b0);
        cyc("t3c8",  2'b10, 2'b10, 16'h41, 16'h50, 2'b10, 1'b1, 16'h50, 2'b01, 16'h41, 1'b0, 1'b1);
        cyc("t3c9",  2'b00, 2'b00, 16'h41, 16'h50, 2'b00, 1'b0, 16'h50, 2'b00, 16'h0,  1'b0, 1'b1);
        cyc("t3c10", 2'b00, 2'b00, 16'h41, 16'h50, 2'b00, 1'b0, 16'h50, 2'b10, 16'h50, 1'b0, 1'b1);
        cyc("t3c11", 2'b00, 2'b00, 16'h41, 16'h50, 2'b00, 1'b0, 16'h50, 2'b00, 16'h0,  1'b1, 1'b1);

        // Back-to-back switch; latency-3 instance sees responses 2 cycles apart
        do_reset("t4");
        cyc("t4c1",  2'b11, 2'b00, 16'h60, 16'h70, 2'b00, 1'b0, 16'h00, 2'b00, 16'h0,  1'b1, 1'b1);
        chk3("t4c1", 2'b00, 16'h0, 1'b1);
        cyc("t4c2",  2'b11, 2'b00, 16'h60, 16'h70, 2'b01, 1'b1, 16'h60, 2'b00, 16'h0,  1'b0, 1'b0);
        cyc("t4c3",  2'b11, 2'b01, 16'h61, 16'h70, 2'b01, 1'b1, 16'h61, 2'b00, 16'h0,  1'b0, 1'b0);
        cyc("t4c4",  2'b10, 2'b00, 16'h61, 16'h70, 2'b00, 1'b0, 16'h61, 2'b01, 16'h60, 1'b0, 1'b0);
        chk3("t4c4", 2'b00, 16'h0, 1'b0);
        cyc("t4c5",  2'b10, 2'b00, 16'h61, 16'h70, 2'b10, 1'b1, 16'h70, 2'b01, 16'h61, 1'b0, 1'b1);
        chk3("t4c5", 2'b01, 16'h60, 1'b0);
        cyc("t4c6",  2'b10, 2'b10, 16'h61, 16'h71, 2'b10, 1'b1, 16'h71, 2'b00, 16'h0,  1'b0, 1'b1);
        chk3("t4c6", 2'b01, 16'h61, 1'b0);
        cyc("t4c7",  2'b00, 2'b00, 16'h61, 16'h71, 2'b00, 1'b0, 16'h71, 2'b10, 16'h70, 1'b0, 1'b1);
        chk3("t4c7", 2'b00, 16'h0, 1'b0);
        cyc("t4c8",  2'b00, 2'b00, 16'h61, 16'h71, 2'b00, 1'b0, 16'h71, 2'b10, 16'h71, 1'b0, 1'b1);
        chk3("t4c8", 2'b10, 16'h70, 1'b0);
        cyc("t4c9",  2'b00, 2'b00, 16'h61, 16'h71, 2'b00, 1'b0, 16'h71, 2'b00, 16'h0,  1'b1, 1'b1);
        chk3("t4c9", 2'b10, 16'h71, 1'b0);
        cyc("t4c10", 2'b00, 2'b00, 16'h61, 16'h71, 2'b00, 1'b0, 16'h71, 2'b00, 16'h0,  1'b1, 1'b1);
        chk3("t4c10", 2'b00, 16'h0, 1'b1);

        // Asynchronous reset with two reads in flight
        do_reset("t5");
        cyc("t5c1", 2'b01, 2'b00, 16'h80, 16'h0, 2'b00, 1'b0, 16'h00, 2'b00, 16'h0, 1'b1, 1'b1);
        cyc("t5c2", 2'b01, 2'b00, 16'h80, 16'h0, 2'b01, 1'b1, 16'h80, 2'b00, 16'h0, 1'b0, 1'b0);
        cyc("t5c3", 2'b01, 2'b00, 16'h81, 16'h0, 2'b01, 1'b1, 16'h81, 2'b00, 16'h0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        bus2.req_addr0 = 16'h82;
        #1;
        chk("t5 pre-reset rsp_valid", bus2.rsp_valid, 2'b01);
        chk("t5 pre-reset rsp_data", bus2.rsp_data, cdata(16'h80));
        #1;
        resetn = 1'b0;
        #1;
        chk_reset("t5 async");
        @(posedge clk);
        #1;
        bus2.req_valid = 2'b00;
        resetn         = 1'b1;
        cyc("t5c5", 2'b00, 2'b00, 16'h82, 16'h0, 2'b00, 1'b0, 16'h00, 2'b00, 16'h0, 1'b1, 1'b1);
        chk3("t5c5", 2'b00, 16'h0, 1'b1);
        cyc("t5c6", 2'b00, 2'b00, 16'h82, 16'h0, 2'b00, 1'b0, 16'h00, 2'b00, 16'h0, 1'b1, 1'b1);
        chk3("t5c6", 2'b00, 16'h0, 1'b1);
        cyc("t5c7", 2'b00, 2'b00, 16'h82, 16'h0, 2'b00, 1'b0, 16'h00, 2'b00, 16'h0, 1'b1, 1'b1);

        // Single-beat bursts from both: grants alternate 0,1,0,1 with bubbles
        cyc("t6c1",  2'b11, 2'b11, 16'h90, 16'hA0, 2'b00, 1'b0, 16'h00, 2'b00, 16'h0,  1'b1, 1'b1);
        cyc("t6c2",  2'b11, 2'b11, 16'h90, 16'hA0, 2'b01, 1'b1, 16'h90, 2'b00, 16'h0,  1'b0, 1'b0);
        cyc("t6c3",  2'b11, 2'b11, 16'h90, 16'hA0, 2'b00, 1'b0, 16'h90, 2'b00, 16'h0,  1'b0, 1'b0);
        cyc("t6c4",  2'b11, 2'b11, 16'h90, 16'hA0, 2'b10, 1'b1, 16'hA0, 2'b01, 16'h90, 1'b0, 1'b1);
        cyc("t6c5",  2'b11, 2'b11, 16'h90, 16'hA0, 2'b00, 1'b0, 16'hA0, 2'b00, 16'h0,  1'b0, 1'b1);
        cyc("t6c6",  2'b11, 2'b11, 16'h90, 16'hA0, 2'b01, 1'b1, 16'h90, 2'b10, 16'hA0, 1'b0, 1'b0);
        cyc("t6c7",  2'b11, 2'b11, 16'h90, 16'hA0, 2'b00, 1'b0, 16'h90, 2'b00, 16'h0,  1'b0, 1'b0);
        cyc("t6c8",  2'b11, 2'b11, 16'h90, 16'hA0, 2'b10, 1'b1, 16'hA0, 2'b01, 16'h90, 1'b0, 1'b1);
        cyc("t6c9",  2'b00, 2'b00, 16'h90, 16'hA0, 2'b00, 1'b0, 16'hA0, 2'b00, 16'h0,  1'b0, 1'b1);
        cyc("t6c10", 2'b00, 2'b00, 16'h90, 16'hA0, 2'b00, 1'b0, 16'hA0, 2'b10, 16'hA0, 1'b0, 1'b1);
        cyc("t6c11", 2'b00, 2'b00, 16'h90, 16'hA0, 2'b00, 1'b0, 16'hA0, 2'b00, 16'h0,  1'b1, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/integral_read_arbiter.md
Name: integral_read_arbiter

Overview:
- Shares the single read port of the integral image cache between the variance loader (requester 0) and the window loader (requester 1).
- Replaces the start-pulse-driven select with a request/grant handshake and round-robin arbitration.
- Grants are locked for whole bursts, and each read response is routed back to the requester that issued it.
- Sits inside the computation block, between both loaders and the integral image cache.

Parameters:
- ADDR_W, 16, cache read address width
- DATA_W, 32, cache read data width
- RD_LATENCY, 2, cycles from cache_rd_en to valid cache_rd_data (legal range 1..4)

Ports:
- clk  in  1  system clock
- resetn  in  1  reset, asynchronous active-low
- req_valid  in  2  per-requester read beat valid; [0]=var loader, [1]=win loader
- req_addr0  in  ADDR_W  requester 0 read address
- req_addr1  in  ADDR_W  requester 1 read address
- req_last  in  2  per-requester: this beat ends the burst
- req_ready  out  2  per-requester: beat accepted this cycle when valid&ready
- rsp_valid  out  2  per-requester: rsp_data belongs to this requester
- rsp_data  out  DATA_W  read data, broadcast to both requesters
- cache_rd_en  out  1  cache read strobe
- cache_addr  out  ADDR_W  cache read address
- cache_rd_data  in  DATA_W  cache read data, valid RD_LATENCY cycles after cache_rd_en
- idle  out  1  no owner and no reads in flight
- grant_owner  out  1  current/last owner id, for debug

Behaviour:
Reset values:
- Reset is asynchronous. While resetn=0: req_ready=0, rsp_valid=0, cache_rd_en=0, cache_addr=0, idle=1, grant_owner=1.
- The round-robin pointer resets to "last served = 1", so requester 0 wins the first contention.

FSM states: IDLE, OWN0, OWN1.
- IDLE:
  - No beats are accepted; req_ready=00.
  - If exactly one req_valid bit is set, go to OWN of that requester.
  - If both are set, go to OWN of the requester not last served.
  - Arbitration costs exactly 1 cycle: a beat presented in IDLE is accepted no earlier than the next cycle.
- OWNi:
  - req_ready[i]=1 and req_ready[other]=0.
  - Beat acceptance = req_valid[i] & req_ready[i]. In the same cycle: cache_rd_en=1, cache_addr=req_addr_i (combinational pass-through).
  - Ownership is held while req_valid[i]=0 mid-burst. There is no timeout, and the other requester waits.
  - An accepted beat with req_last[i]=1 moves the FSM to IDLE and sets last served = i.
  - The mandatory 1-cycle IDLE bubble lets the other requester win the next grant.
- cache_rd_en=0 whenever no beat is accepted. cache_addr holds its last value when idle.

Response routing:
- Shift register of RD_LATENCY entries, each {valid, id}, advanced every cycle.
- The entry is loaded with {1, owner} on each accepted beat and {0, x} otherwise.
- rsp_valid[id] = tail.valid & (tail.id == id). Requests and responses are in-order with no backpressure, so the requester must sink every beat.
- rsp_data = cache_rd_data, passed through combinationally.

Other outputs:
- idle = (state == IDLE) & no valid entries in the shift register. The master controller waits on idle before changing phase.
- grant_owner = id of the current owner; in IDLE it shows the last served id.

Corner cases:
- Simultaneous last-beat and new request from the other requester: resolved via IDLE on the next cycle. No grant is ever given to both requesters.
- Requester 0 and requester 1 responses may overlap in the pipe across a switch. Each response is tagged independently, so there is no cross-delivery.
- Async reset mid-burst clears the FSM and the shift register. In-flight responses are dropped and no rsp_valid is asserted after reset.
- req_last asserted with req_valid=0 is ignored.

Decomposition:
- Shared package holds:
  - requester id constants REQ_VAR=0 and REQ_WIN=1
  - the FSM state enum
  - the typedef of the response tag entry {valid, id}
- One natural sub-module, rsp_tag_pipe: a parameterised RD_LATENCY-deep valid/id shift register with async clear and an any-valid output.

Test Plan:
- Reset, then req_valid=01 with a 4-beat burst (addrs 0x10..0x13, last on 4th) -> grant on cycle 2. Four consecutive cache_rd_en with those addrs; rsp_valid=01 for 4 cycles starting RD_LATENCY later; idle=1 afterwards.
- Both requests asserted from IDLE after reset -> OWN0 first. After requester 0's last beat, 1 IDLE cycle, then OWN1. On the next contention requester 0 wins again only after requester 1 has been served.
- Owner drops req_valid for 3 cycles mid-burst while the other requests -> ownership held, req_ready[other]=0 throughout, no cache_rd_en during the gap.
- Back-to-back switch with RD_LATENCY=3: requester 0's last response and requester 1's first response are 2 cycles apart -> each appears only on its own rsp_valid bit with the correct data.
- Assert resetn=0 asynchronously with 2 reads in flight -> outputs clear immediately, no rsp_valid after release, idle=1.
- Single-beat bursts (req_last=1 every beat) alternating from both requesters -> grants alternate 0,1,0,1 with one bubble between each.
